// File: rtl/level1v_decode_if.sv
// Request/result bundle for level1v_decode. Handshake: a request transfers on a rising
// edge where start && ready; done is a one-cycle pulse marking fresh result outputs.
interface level1v_decode_if #(parameter int VBITS = 6);
  logic             start;
  logic [31:0]      level;
  logic             ready;
  logic             done;
  logic [VBITS-1:0] value;
  logic [12:0]      remainder;
  logic             under;
  logic             over;
  logic [1:0]       dbg_state;

  modport master (
    output start, level,
    input  ready, done, value, remainder, under, over, dbg_state
  );

  modport slave (
    input  start, level,
    output ready, done, value, remainder, under, over, dbg_state
  );
endinterface

// File: rtl/level1v_decode.sv
// Recovers the 10 uV offset index above 1 V from a level word by restoring division.
// Define LEVEL1V_DECODE_ROUND_EN to round the index to nearest instead of truncating.
module level1v_decode #(
  parameter logic [31:0] BASE  = 32'd429359290,
  parameter int          STEP  = 4295,
  parameter int          VBITS = 6
) (
  input logic             clk,
  input logic             rst_n,
  level1v_decode_if.slave bus
);
  // Working remainder stays below STEP<<VBITS once the range check has passed.
  localparam int RW = 13 + VBITS;
  localparam int IW = (VBITS > 1) ? $clog2(VBITS) : 1;
  localparam logic [32:0]      LIMIT   = 33'(STEP) << VBITS;
  localparam logic [RW-1:0]    STEP_RW = RW'(STEP);
  localparam logic [VBITS-1:0] VMAX    = '1;
`ifdef LEVEL1V_DECODE_ROUND_EN
  localparam logic [RW-1:0]    HALF    = RW'((STEP + 1) / 2);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DIV = 2'd2} state_t;

  state_t           state, state_n;
  logic [31:0]      lvl, lvl_n;
  logic [RW-1:0]    r, r_n;
  logic [VBITS-1:0] q, q_n;
  logic [IW-1:0]    i, i_n;
  logic [VBITS-1:0] value_q, value_n;
  logic [12:0]      rem_q, rem_n;
  logic             under_q, under_n;
  logic             over_q, over_n;
  logic             done_q, done_n;

  logic [32:0]      diff;
  logic [RW-1:0]    trial;
  logic [RW-1:0]    r_upd;
  logic [VBITS-1:0] q_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lvl     <= '0;
      r       <= '0;
      q       <= '0;
      i       <= '0;
      value_q <= '0;
      rem_q   <= '0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      lvl     <= lvl_n;
      r       <= r_n;
      q       <= q_n;
      i       <= i_n;
      value_q <= value_n;
      rem_q   <= rem_n;
      under_q <= under_n;
      over_q  <= over_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    r_n     = r;
    q_n     = q;
    i_n     = i;
    value_n = value_q;
    rem_n   = rem_q;
    under_n = under_q;
    over_n  = over_q;
    done_n  = 1'b0;
    diff    = {1'b0, lvl} - {1'b0, BASE};
    trial   = STEP_RW << i;
    r_upd   = r;
    q_upd   = q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          lvl_n   = bus.level;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (diff[32]) begin
          under_n = 1'b1;
          over_n  = 1'b0;
          value_n = '0;
          rem_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (diff >= LIMIT) begin
          under_n = 1'b0;
          over_n  = 1'b1;
          value_n = VMAX;
          rem_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          r_n     = diff[RW-1:0];
          q_n     = '0;
          i_n     = IW'(VBITS - 1);
          state_n = DIV;
        end
      end
      DIV: begin
        if (r >= trial) begin
          r_upd = r - trial;
          q_upd = q | (VBITS'(1) << i);
        end
        r_n = r_upd;
        q_n = q_upd;
        if (i == '0) begin
          value_n = q_upd;
`ifdef LEVEL1V_DECODE_ROUND_EN
          // Round up on the upper half of a step, but never past the top code.
          if (r_upd >= HALF && q_upd != VMAX)
            value_n = q_upd + VBITS'(1);
`endif
          rem_n   = r_upd[12:0];
          under_n = 1'b0;
          over_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          i_n = i - IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.value     = value_q;
  assign bus.remainder = rem_q;
  assign bus.under     = under_q;
  assign bus.over      = over_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_level1v_decode.sv
// Randomized scoreboard bench for level1v_decode: expected results and done cycles are
// queued at acceptance and checked by an independent monitor on every done pulse.
module tb_level1v_decode;
  localparam logic [31:0] BASE  = 32'd429359290;
  localparam int          STEP  = 4295;
  localparam int          VBITS = 6;
  localparam int          W     = 2 + VBITS + 13;
  localparam longint      SPAN  = longint'(STEP) * (2 ** VBITS);

  logic clk;
  logic rst_n;
  int   cyc;
  int   compared;
  int   mismatched;
  logic prev_done;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  level1v_decode_if #(.VBITS(VBITS)) bus();

  level1v_decode #(.BASE(BASE), .STEP(STEP), .VBITS(VBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: level = BASE + n*STEP + rem, with saturation at both ends
  function automatic logic [W-1:0] model(input logic [31:0] lv, output int lat);
    longint d;
    longint n;
    longint rm;
    d = longint'(lv) - longint'(BASE);
    if (d < 0) begin
      lat = 1;
      return {1'b1, 1'b0, VBITS'(0), 13'd0};
    end
    if (d >= SPAN) begin
      lat = 1;
      return {1'b0, 1'b1, VBITS'(2 ** VBITS - 1), 13'd0};
    end
    n  = d / STEP;
    rm = d % STEP;
`ifdef LEVEL1V_DECODE_ROUND_EN
    if (rm >= (STEP + 1) / 2 && n < 2 ** VBITS - 1) n = n + 1;
`endif
    lat = 1 + VBITS;
    return {1'b0, 1'b0, VBITS'(n), 13'(rm)};
  endfunction

  function automatic int push_exp(input logic [31:0] lv, input int acc_cyc);
    int lat;
    exp_q.push_back(model(lv, lat));
    lat_q.push_back(acc_cyc + lat);
    return lat;
  endfunction

  function automatic logic [31:0] rand_level();
    case ($urandom_range(0, 4))
      0: return BASE - 32'($urandom_range(1, 50));
      1: return BASE + 32'(SPAN) + 32'($urandom_range(0, 50)) - 32'd25;
      2: return $urandom;
      default: return BASE + 32'($urandom_range(0, int'(SPAN) - 1));
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: wait for ready, present one request for exactly the accepting edge
  task automatic issue(input logic [31:0] lv);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", bus.ready, 1);
    if (bus.ready) begin
      bus.start = 1'b1;
      bus.level = lv;
      lat = push_exp(lv, cyc + 1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.level = $urandom;
    end
  endtask

  // Hold start high with alternating in-range / under levels; accepts must be back-to-back
  task automatic stream(input int n);
    int acc;
    int guard;
    int last;
    int gap;
    logic [31:0] lv;
    acc = 0; guard = 0; last = -1; gap = 0;
    while (acc < n && guard < 400) begin
      @(negedge clk);
      guard++;
      lv = (acc % 2 == 0) ? BASE + 32'($urandom_range(0, int'(SPAN) - 1))
                          : BASE - 32'($urandom_range(1, 1000));
      bus.start = 1'b1;
      bus.level = lv;
      if (bus.ready) begin
        if (last >= 0) check("stream_gap", cyc + 1 - last, gap + 1);
        gap  = push_exp(lv, cyc + 1);
        last = cyc + 1;
        acc++;
      end
    end
    check("stream_accepts", acc, n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Monitor / scoreboard
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      compared++;
      if (prev_done) begin
        mismatched++;
        $display("FAIL done_width: done high for 2 cycles at cycle %0d", cyc);
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: got done with no request pending at cycle %0d", cyc);
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        int el;
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        a  = {bus.under, bus.over, bus.value, bus.remainder};
        if (a !== e) begin
          mismatched++;
          $display("FAIL result: got under=%0b over=%0b value=%0d rem=%0d expected under=%0b over=%0b value=%0d rem=%0d",
                   a[W-1], a[W-2], a[12+VBITS:13], a[12:0], e[W-1], e[W-2], e[12+VBITS:13], e[12:0]);
        end
        check("done_cycle", cyc, el);
      end
    end
    prev_done = rst_n ? bus.done : 1'b0;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.ready, 1);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_value"}, bus.value, 0);
    check({tag, "_rem"}, bus.remainder, 0);
    check({tag, "_flags"}, {bus.under, bus.over}, 0);
  endtask

  initial begin
    logic [31:0] dir[7];
    int guard;
    compared = 0;
    mismatched = 0;
    bus.start = 1'b0;
    bus.level = '0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed boundary cases
    dir = '{32'd429359290, 32'd429402340, 32'd429634169, 32'd429359289,
            32'd429634170, 32'hFFFFFFFF, 32'd429382913};
    foreach (dir[k]) issue(dir[k]);

    // Randomized requests with random idle gaps
    for (int k = 0; k < 40; k++) begin
      issue(rand_level());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    stream(8);

    // Start while busy must be ignored
    issue(BASE + 32'($urandom_range(0, int'(SPAN) - 1)));
    repeat (2) @(negedge clk);
    check("busy_ready", bus.ready, 0);
    bus.start = 1'b1;
    bus.level = BASE + 32'd100000;
    @(negedge clk);
    bus.start = 1'b0;

    // Reset during the 4th division cycle
    issue(BASE + 32'd200000);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(32'd429402340);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/level1v_decode.md
# level1v_decode

Inverse of the 1 V target generator. Takes a 32-bit level in the same scale as the PWM target word and recovers the 6-bit offset index `n`, where the level equals `1 V + n * 10 uV`. It uses a sequential restoring division and reports the remainder plus saturation flags. It sits on the readback/monitor path next to the ANS PWM loop, so software and other blocks can check which target code a measured or programmed level corresponds to.

## Interface
- `BASE`, default 429359290: level word for 1 V, the offset origin.
- `STEP`, default 4295: level word per 10 uV step. Must satisfy 0 < STEP < 8192.
- `VBITS`, default 6: index width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request. Sampled only while `ready`=1.
- `level` in 32: unsigned level word. Sampled on the edge that accepts `start`.
- `ready` out 1: block idle and able to accept `start`.
- `done` out 1: one-cycle pulse; result outputs are valid from this cycle.
- `value` out VBITS: decoded index.
- `remainder` out 13: `(level - BASE) mod STEP` on the in-range path; 0 when `under` or `over` is set.
- `under` out 1: `level` < `BASE`.
- `over` out 1: `level` >= `BASE + STEP*2^VBITS`.

## Operation
- FSM states: IDLE, CHECK, DIV.
- **IDLE** (`ready`=1):
  - If `start`=1: latch `level`, go to CHECK.
  - Otherwise stay in IDLE.
- **CHECK**:
  - Compute `diff = {1'b0,level} - {1'b0,BASE}` at 33 bits.
  - If `diff` is negative: `under`=1, `over`=0, `value`=0, `remainder`=0, pulse `done`, go to IDLE.
  - Else if `diff` >= `STEP<<VBITS` (compared at 33 bits): `over`=1, `under`=0, `value`=2^VBITS-1, `remainder`=0, pulse `done`, go to IDLE.
  - Else: load the working remainder `r` with `diff`, which fits in 19 bits for the defaults. Clear the quotient `q`, set iteration counter `i`=VBITS-1, go to DIV.
- **DIV**, one iteration per cycle, VBITS iterations in total:
  - If `r` >= `STEP<<i`, then `r -= STEP<<i` and `q[i]`=1.
  - When `i`=0:
    - Register `value`=`q` (after this iteration's update) and `remainder`=`r[12:0]`.
    - Clear `under` and `over`, pulse `done`, go to IDLE.
  - Otherwise decrement `i`.
- Result outputs (`value`, `remainder`, `under`, `over`) hold their last result until the next `done`. They are not disturbed while a new computation is running.
- `start` while `ready`=0 is ignored and not queued. `level` changes while busy have no effect.
- Exactly one of these holds at `done`: `under`, `over`, or in-range (both flags 0).

## Timing
- Reset values, asynchronous and immediate:
  - `ready`=1, `done`=0, `value`=0, `remainder`=0, `under`=0, `over`=0.
  - State IDLE, internal registers 0.
- Reset asserted mid-computation aborts it; no `done` is produced.
- Take edge k as the edge that accepts `start`. `ready` falls after edge k.
- Saturated path (`under` or `over`): results update and `done`=1 after edge k+1. Latency is 1 cycle.
- In-range path: DIV iterations run on edges k+2 … k+1+VBITS. Results update and `done`=1 after edge k+1+VBITS, which is 7 cycles for VBITS=6.
- `ready` returns to 1 in the same cycle that `done`=1. A `start` in that cycle is accepted, giving back-to-back throughput of 8 cycles per in-range decode.
- `done` is never high for more than one consecutive cycle.

## Configuration
- `LEVEL1V_DECODE_ROUND_EN` defined: round-to-nearest.
  - On the in-range path, if the final `r` >= `(STEP+1)/2` (2148 for defaults), `value` = `q+1`, saturating at 2^VBITS-1 without setting `over`.
  - `remainder` still reports the raw `r`.
  - Latency is unchanged.
- `LEVEL1V_DECODE_ROUND_EN` not defined: truncation, `value` = `q`.

## Test plan
- Exact base: `level`=429359290 -> after 7 cycles `done`=1, `value`=0, `remainder`=0, `under`=0, `over`=0.
- In-range with remainder: `level`=429402340 -> `value`=10, `remainder`=100. Also `level`=429634169 -> `value`=63, `remainder`=4294, `over`=0.
- Saturation:
  - `level`=429359289 -> `under`=1, `value`=0, `done` 1 cycle after acceptance.
  - `level`=429634170 -> `over`=1, `value`=63, `remainder`=0.
  - `level`=0xFFFFFFFF -> `over`=1.
- Rounding, `level`=429382913:
  - With `LEVEL1V_DECODE_ROUND_EN`: `value`=6, `remainder`=2148.
  - Without it: `value`=5, `remainder`=2148.
  - With the macro, `level`=429634169 -> `value`=63 and `over`=0.
- Handshake:
  - Hold `start` high continuously with alternating levels; check each `done` is a single-cycle pulse and the next request is accepted in the `done` cycle.
  - Pulse `start` 3 cycles into a decode with a different `level`; it must be ignored.
- Reset: deassert `rst_n` at the 4th DIV cycle -> `ready`=1 and all result outputs 0 immediately; no `done` pulse follows. The next request decodes correctly.
